// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for one single-ported synchronous RAM: data wins by default,
// a saturating starvation counter forces a fetch grant, read data returns one cycle later.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int MW         = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_byteen,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [MW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_rd_owner_o,
  output logic [3:0]    dbg_starve_cnt_o
);

  // Handshake: a request (x_req) is accepted in the cycle x_gnt is high; the
  // requester holds its command stable until then. Read data is qualified by
  // x_rvalid exactly one cycle after the accepting cycle; there is no back-pressure.

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } rd_owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  rd_owner_e  rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       force_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q   <= OWN_NONE;
      starve_cnt_q <= 4'd0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    force_i      = i_req & (starve_cnt_q == STARVE_LIM);
    // Grants are gated by reset so nothing reaches the RAM while it is held.
    d_gnt        = reset & d_req & ~force_i;
    i_gnt        = reset & i_req & ~d_gnt;
    mem_en       = i_gnt | d_gnt;
    mem_we       = (d_gnt & d_we) ? d_byteen : 4'd0;
    mem_addr     = d_gnt ? d_addr[MW+1:2] : i_addr[MW+1:2];
    mem_wdata    = d_wdata;

    starve_cnt_d = 4'd0;
    if (i_req & ~i_gnt)
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;

    rd_owner_d = OWN_NONE;
    if (i_gnt)
      rd_owner_d = OWN_INSTR;
    else if (d_gnt & ~d_we)
      rd_owner_d = OWN_DATA;
  end

  assign i_rvalid         = (rd_owner_q == OWN_INSTR);
  assign d_rvalid         = (rd_owner_q == OWN_DATA);
  assign i_rdata          = mem_rdata;
  assign d_rdata          = mem_rdata;
  assign dbg_rd_owner_o   = rd_owner_q;
  assign dbg_starve_cnt_o = starve_cnt_q;

  // Byte-offset and upper address bits do not select a RAM word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[AW-1:MW+2], i_addr[1:0], d_addr[AW-1:MW+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM
// and hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int MW = 12;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_byteen;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [MW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [1:0]    dbg_rd_owner;
  logic [3:0]    dbg_starve_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(AW), .MW(MW), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_byteen(d_byteen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dbg_rd_owner_o(dbg_rd_owner), .dbg_starve_cnt_o(dbg_starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM: word k initialised to 0xC0DE0000 | k
  logic [31:0] ram [0:(1<<MW)-1];
  initial begin
    for (int k = 0; k < (1 << MW); k++) ram[k] = 32'hC0DE_0000 | 32'(k);
    mem_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'd0) mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_byteen = be; d_addr = da; d_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    // reset held with both requests pending
    reset = 1'b0;
    drive(1'b1, 32'h3000, 1'b1, 1'b0, 4'hF, 32'h40, 32'd0);
    next_cycle();
    next_cycle();
    #1;
    check("rst_i_gnt",   32'(i_gnt), 32'd0);
    check("rst_d_gnt",   32'(d_gnt), 32'd0);
    check("rst_mem_en",  32'(mem_en), 32'd0);
    check("rst_mem_we",  32'(mem_we), 32'd0);
    check("rst_rvalid",  32'({i_rvalid, d_rvalid}), 32'd0);
    check("rst_starve",  32'(dbg_starve_cnt), 32'd0);
    check("rst_owner",   32'(dbg_rd_owner), 32'd0);

    // release: data first, then D,D,D,I repeating
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic exp_d;
      logic prev_d;
      if (c > 0) next_cycle();
      #1;
      exp_d  = ((c % 4) != 3);
      prev_d = ((c - 1) % 4) != 3;
      check($sformatf("pat%0d_d_gnt", c), 32'(d_gnt), 32'(exp_d));
      check($sformatf("pat%0d_i_gnt", c), 32'(i_gnt), 32'(!exp_d));
      check($sformatf("pat%0d_starve", c), 32'(dbg_starve_cnt), 32'(c % 4));
      check($sformatf("pat%0d_mem_addr", c), 32'(mem_addr), exp_d ? 32'h10 : 32'hC00);
      if (c > 0) begin
        check($sformatf("pat%0d_d_rvalid", c), 32'(d_rvalid), 32'(prev_d));
        check($sformatf("pat%0d_i_rvalid", c), 32'(i_rvalid), 32'(!prev_d));
        if (prev_d) check($sformatf("pat%0d_d_rdata", c), d_rdata, 32'hC0DE_0010);
        else        check($sformatf("pat%0d_i_rdata", c), i_rdata, 32'hC0DE_0C00);
      end
    end
    next_cycle();
    idle();
    #1;
    check("tail_i_rvalid", 32'(i_rvalid), 32'd1);
    check("tail_i_rdata",  i_rdata, 32'hC0DE_0C00);
    check("idle_mem_en",   32'(mem_en), 32'd0);
    check("idle_gnts",     32'({i_gnt, d_gnt}), 32'd0);

    // fetch only at 0x3000
    next_cycle();
    drive(1'b1, 32'h3000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("ifetch_i_gnt",    32'(i_gnt), 32'd1);
    check("ifetch_d_gnt",    32'(d_gnt), 32'd0);
    check("ifetch_mem_addr", 32'(mem_addr), 32'hC00);
    check("ifetch_mem_en",   32'(mem_en), 32'd1);
    next_cycle();
    idle();
    #1;
    check("ifetch_i_rvalid", 32'(i_rvalid), 32'd1);
    check("ifetch_i_rdata",  i_rdata, 32'hC0DE_0C00);
    check("ifetch_d_rvalid", 32'(d_rvalid), 32'd0);

    // partial write then read-back of the same word
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD);
    #1;
    check("wr_d_gnt",     32'(d_gnt), 32'd1);
    check("wr_mem_we",    32'(mem_we), 32'h3);
    check("wr_mem_addr",  32'(mem_addr), 32'h4);
    check("wr_mem_wdata", mem_wdata, 32'hAABB_CCDD);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h10, 32'd0);
    #1;
    check("wr_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    check("rd_mem_we",    32'(mem_we), 32'd0);
    check("rd_d_gnt",     32'(d_gnt), 32'd1);
    next_cycle();
    idle();
    #1;
    check("rd_d_rvalid",  32'(d_rvalid), 32'd1);
    check("rd_d_rdata",   d_rdata, 32'hC0DE_CCDD);

    // write with no byte lanes enabled
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
    #1;
    check("be0_d_gnt",  32'(d_gnt), 32'd1);
    check("be0_mem_en", 32'(mem_en), 32'd1);
    check("be0_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h20, 32'd0);
    #1;
    check("be0_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    next_cycle();
    idle();
    #1;
    check("be0_rd_rvalid", 32'(d_rvalid), 32'd1);
    check("be0_rd_rdata",  d_rdata, 32'hC0DE_0008);

    // read granted while fetch loses, reset asserted the next cycle
    next_cycle();
    drive(1'b1, 32'h3000, 1'b1, 1'b0, 4'd0, 32'h10, 32'd0);
    #1;
    check("rr_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    reset = 1'b0;
    idle();
    #1;
    check("rr_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rr_starve",   32'(dbg_starve_cnt), 32'd0);
    next_cycle();
    reset = 1'b1;
    #1;
    check("rr_post_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rr_post_starve",   32'(dbg_starve_cnt), 32'd0);
    check("rr_post_owner",    32'(dbg_rd_owner), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
